wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port among NUM_SRC writeback producers
//   (source 0 = ALU pipe, 1 = LSU, 2 = MUL/DIV). Sits between the producers and the RF.
// - Priority is fixed, lowest index first. An age counter per source prevents starvation.
// - Output is registered: one RF write per cycle, one cycle after the grant.
// PARAMETERS
// - NUM_SRC       3   number of writeback requesters; must be >= 2
// - DATA_W        32  write data width; from rv32_pkg
// - ADDR_W        5   RF address width; from rv32_pkg RF_ADDR_WIDTH
// - STARVE_LIMIT  4   wait cycles (1..15) before a source is promoted to the starved class
// PORTS
// - clk_i           in   1                  clock
// - rst_ni          in   1                  asynchronous reset, active-low
// - flush_i         in   1                  pipeline flush: drop grants this cycle, clear ages
// - stall_i         in   1                  RF port unavailable (CSR access in WB): no grants
// - src_valid_i     in   NUM_SRC            per-source write request
// - src_ready_o     out  NUM_SRC            per-source grant; one-hot or zero
// - src_addr_i      in   NUM_SRC*ADDR_W     flattened destination addresses; source i at [i*ADDR_W +: ADDR_W]
// - src_data_i      in   NUM_SRC*DATA_W     flattened write data, same packing
// - rf_we_o         out  1                  RF write enable (registered)
// - rf_waddr_o      out  ADDR_W             RF write address (registered)
// - rf_wdata_o      out  DATA_W             RF write data (registered)
// - rf_src_o        out  $clog2(NUM_SRC)    index of the source that owns the current write
// - conflict_cnt_o  out  16                 saturating count of cycles with >=2 valid requesters
// BEHAVIOUR
// - Reset: all outputs are 0 asynchronously, age counters are 0, and conflict_cnt_o is 0.
//   A reset in mid-operation discards any registered write.
// - Handshake: a transfer occurs when src_valid_i[i] && src_ready_o[i] at a clk edge.
//   - A producer holds its addr/data stable while valid && !ready.
//   - A producer must not drop valid before it is granted, except on flush_i.
// - src_ready_o is combinational from valid, ages, stall_i and flush_i. At most one bit is set.
//   It is all-zero when stall_i or flush_i is high.
// - Grant selection:
//   - Starved class: sources with age[i] == STARVE_LIMIT. If this class is non-empty, the
//     lowest index in it wins.
//   - Otherwise the lowest-index valid source wins.
// - Age counter age[i], width $clog2(STARVE_LIMIT+1):
//   - Increments when valid && !ready and stall_i == 0, saturating at STARVE_LIMIT.
//   - Clears on a grant, when valid is low, or when flush_i is high.
//   - Holds its value while stall_i is high.
// - Latency: a grant in cycle N sets rf_we_o/rf_waddr_o/rf_wdata_o/rf_src_o in cycle N+1
//   for exactly one cycle. With no grant, rf_we_o = 0 next cycle; addr/data/src hold their
//   last values.
// - x0 writes: the transfer is accepted (ready = 1, age cleared), but rf_we_o stays 0.
//   rf_src_o is still updated.
// - Flush: the write already registered in cycle N (from a grant in N-1) still completes.
//   There is no grant in cycle N, so rf_we_o = 0 in N+1.
// - Simultaneous flush_i and stall_i: flush_i behaviour applies (ages cleared).
// - conflict_cnt_o increments when popcount(src_valid_i) >= 2, regardless of stall_i.
//   It saturates at 16'hFFFF.
// STRUCTURE
// - rv32_pkg: DATA_W, RF_ADDR_WIDTH (existing) plus new constants WB_SRC_ALU=0,
//   WB_SRC_LSU=1, WB_SRC_MDU=2 and WB_NUM_SRC=3.
// - Sub-module wb_arb_age_ctr: one per source. Inputs valid/grant/stall/flush; outputs age and
//   starved flag. Generated with a for-loop.
// - Top level: priority pick over {starved, valid}, output register, conflict counter.
// TESTING
// - Single request: src1 valid, addr=5, data=32'hDEAD_BEEF
//   -> ready1=1 in the same cycle; next cycle rf_we_o=1, waddr=5, wdata=DEAD_BEEF, rf_src_o=1.
// - Contention: src0 and src2 continuously valid, STARVE_LIMIT=4
//   -> src0 is granted for 4 cycles, src2 is granted in the 5th; conflict_cnt_o=5 after 5 cycles.
// - x0 write: src0 valid, addr=0 -> ready0=1, next cycle rf_we_o=0, rf_src_o=0.
// - Stall: stall_i held high for 3 cycles while src1 and src2 are valid
//   -> no grants and ages are frozen; after stall drops, src1 is granted first.
// - Flush: src1 age=3 and flush_i pulsed
//   -> ready=0 in the flush cycle, age=0 afterwards; a write registered before the flush
//      still asserts rf_we_o.
// - Async reset while rf_we_o=1 -> rf_we_o, rf_waddr_o, rf_wdata_o and conflict_cnt_o go to 0
//   immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32_pkg.sv
// Core-wide constants shared by the RV32 pipeline blocks.
package rv32_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    // Writeback producer indices; lower index wins on a plain priority pick.
    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LSU = 1;
    localparam int unsigned WB_SRC_MDU = 2;
    localparam int unsigned WB_NUM_SRC = 3;

endpackage

// File: rtl/wb_arb_age_ctr.sv
// Per-source wait counter for the writeback arbiter; flags a source as starved
// once it has waited STARVE_LIMIT unstalled cycles.
module wb_arb_age_ctr #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             grant_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [AGE_W-1:0] age_o,
    output logic             starved_o
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age_q, age_d;

    // Flush beats stall so a flushed pipeline never carries stale ages.
    always_comb begin
        age_d = age_q;
        if (flush_i) begin
            age_d = '0;
        end else if (!stall_i) begin
            if (!valid_i || grant_i) begin
                age_d = '0;
            end else if (age_q != LIMIT) begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_o     = age_q;
    assign starved_o = (age_q == LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port among the writeback producers: fixed priority
// with starvation promotion, registered write, and a contention counter.
module wb_port_arbiter #(
    parameter int unsigned NUM_SRC      = rv32_pkg::WB_NUM_SRC,
    parameter int unsigned DATA_W       = rv32_pkg::DATA_W,
    parameter int unsigned ADDR_W       = rv32_pkg::RF_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    output logic [NUM_SRC-1:0]         src_ready_o,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data_i,
    output logic                       rf_we_o,
    output logic [ADDR_W-1:0]          rf_waddr_o,
    output logic [DATA_W-1:0]          rf_wdata_o,
    output logic [$clog2(NUM_SRC)-1:0] rf_src_o,
    output logic [15:0]                conflict_cnt_o
);
    import rv32_pkg::*;

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_SRC-1:0]            starved;
    logic [NUM_SRC-1:0]            cand;
    logic [NUM_SRC-1:0]            grant;
    logic [NUM_SRC-1:0][AGE_W-1:0] age;
    logic                          any_grant;
    logic [SRC_W-1:0]              sel_idx;
    logic [ADDR_W-1:0]             sel_addr;
    logic [DATA_W-1:0]             sel_data;

    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [SRC_W-1:0]  rf_src_q,   rf_src_d;
    logic [15:0]       conflict_q, conflict_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_age
        wb_arb_age_ctr #(
            .STARVE_LIMIT (STARVE_LIMIT),
            .AGE_W        (AGE_W)
        ) u_age (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .valid_i   (src_valid_i[i]),
            .grant_i   (grant[i]),
            .stall_i   (stall_i),
            .flush_i   (flush_i),
            .age_o     (age[i]),
            .starved_o (starved[i])
        );

        a_age_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
            age[i] <= AGE_W'(STARVE_LIMIT));
    end

    // Starved requesters form their own class; inside either class lowest index wins.
    always_comb begin
        cand = src_valid_i;
        if (|(starved & src_valid_i)) begin
            cand = starved & src_valid_i;
        end
        grant     = '0;
        any_grant = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && !any_grant) begin
                any_grant = 1'b1;
                grant[i]  = 1'b1;
                sel_idx   = SRC_W'(i);
                sel_addr  = src_addr_i[i*ADDR_W +: ADDR_W];
                sel_data  = src_data_i[i*DATA_W +: DATA_W];
            end
        end
        if (stall_i || flush_i) begin
            grant     = '0;
            any_grant = 1'b0;
        end
    end

    assign src_ready_o = grant;

    // x0 writes are consumed but never reach the RF.
    always_comb begin
        rf_we_d    = any_grant && (sel_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_d   = rf_src_q;
        if (any_grant) begin
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
            rf_src_d   = sel_idx;
        end
        conflict_d = conflict_q;
        if (($countones(src_valid_i) >= 2) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= '0;
            conflict_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
            conflict_q <= conflict_d;
        end
    end

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(src_ready_o));

    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign rf_src_o       = rf_src_q;
    assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus constrained-random traffic
// checked against a cycle-level model of the arbitration rules.
module tb_wb_port_arbiter;
    import rv32_pkg::*;

    localparam int NS  = WB_NUM_SRC;
    localparam int AW  = RF_ADDR_WIDTH;
    localparam int DW  = DATA_W;
    localparam int LIM = 4;

    logic              clk_i   = 1'b0;
    logic              rst_ni  = 1'b0;
    logic              flush_i = 1'b0;
    logic              stall_i = 1'b0;
    logic [NS-1:0]     src_valid_i;
    logic [NS-1:0]     src_ready_o;
    logic [NS*AW-1:0]  src_addr_i;
    logic [NS*DW-1:0]  src_data_i;
    logic              rf_we_o;
    logic [AW-1:0]     rf_waddr_o;
    logic [DW-1:0]     rf_wdata_o;
    logic [1:0]        rf_src_o;
    logic [15:0]       conflict_cnt_o;

    logic          v [NS];
    logic [AW-1:0] a [NS];
    logic [DW-1:0] d [NS];

    int            age_m [NS];
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic [1:0]    exp_src;
    int            exp_cnt;
    int            last_win;
    int            n_vec = 0;
    int            n_err = 0;

    wb_port_arbiter #(
        .NUM_SRC      (NS),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .src_valid_i    (src_valid_i),
        .src_ready_o    (src_ready_o),
        .src_addr_i     (src_addr_i),
        .src_data_i     (src_data_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_src_o       (rf_src_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        src_valid_i = '0;
        src_addr_i  = '0;
        src_data_i  = '0;
        for (int i = 0; i < NS; i++) begin
            src_valid_i[i]           = v[i];
            src_addr_i[i*AW +: AW]   = a[i];
            src_data_i[i*DW +: DW]   = d[i];
        end
    end

    // Winner this cycle: waited-too-long requesters first, then plain lowest index.
    function automatic int pick();
        if (stall_i || flush_i) return -1;
        for (int i = 0; i < NS; i++) if (v[i] && age_m[i] == LIM) return i;
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NS-1:0] exp_ready();
        logic [NS-1:0] r;
        int w;
        r = '0;
        w = pick();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) age_m[i] = 0;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_src = '0;
        exp_cnt = 0; last_win = -1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NS; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        int w, nv;
        w  = pick();
        nv = 0;
        for (int i = 0; i < NS; i++) nv += int'(v[i]);
        for (int i = 0; i < NS; i++) begin
            if (flush_i)                 age_m[i] = 0;
            else if (stall_i)            age_m[i] = age_m[i];
            else if (!v[i] || w == i)    age_m[i] = 0;
            else if (age_m[i] < LIM)     age_m[i] = age_m[i] + 1;
        end
        if (w >= 0) begin
            exp_we    = (a[w] != '0);
            exp_waddr = a[w];
            exp_wdata = d[w];
            exp_src   = 2'(w);
        end else begin
            exp_we = 1'b0;
        end
        if (nv >= 2 && exp_cnt < 65535) exp_cnt++;
        last_win = w;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o} !== '0) begin
            n_err++;
            $display("FAIL reset_rf: got %h want 0", {rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o});
        end
        n_vec++;
        if (conflict_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", conflict_cnt_o);
        end
        n_vec++;
        if (src_ready_o !== '0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 000", src_ready_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        v[WB_SRC_LSU] = 1'b1; a[WB_SRC_LSU] = 5'd5; d[WB_SRC_LSU] = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (src_ready_o !== 3'b010) begin
            n_err++;
            $display("FAIL single_ready: got %b want 010", src_ready_o);
        end
        tick();
        v[WB_SRC_LSU] = 1'b0;
        n_vec++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1}) begin
            n_err++;
            $display("FAIL single_write: got we=%b a=%0d d=%h s=%0d want we=1 a=5 d=deadbeef s=1",
                     rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o);
        end
        tick();
        n_vec++;
        if (rf_we_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_we_pulse: got %b want 0", rf_we_o);
        end
    endtask

    task automatic test_x0();
        v[WB_SRC_ALU] = 1'b1; a[WB_SRC_ALU] = 5'd0; d[WB_SRC_ALU] = $urandom;
        #1;
        n_vec++;
        if (src_ready_o !== 3'b001) begin
            n_err++;
            $display("FAIL x0_ready: got %b want 001", src_ready_o);
        end
        tick();
        v[WB_SRC_ALU] = 1'b0;
        n_vec++;
        if ({rf_we_o, rf_src_o} !== {1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL x0_write: got we=%b s=%0d want we=0 s=0", rf_we_o, rf_src_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        v[WB_SRC_ALU] = 1'b1; v[WB_SRC_MDU] = 1'b1;
        a[WB_SRC_MDU] = 5'd17; d[WB_SRC_MDU] = $urandom;
        for (int k = 0; k < 5; k++) begin
            a[WB_SRC_ALU] = 5'(k + 1); d[WB_SRC_ALU] = $urandom;
            #1;
            n_vec++;
            if (src_ready_o !== ((k < 4) ? 3'b001 : 3'b100)) begin
                n_err++;
                $display("FAIL contention_ready[%0d]: got %b want %b", k, src_ready_o,
                         (k < 4) ? 3'b001 : 3'b100);
            end
            tick();
            n_vec++;
            if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o} !== {exp_we, exp_waddr, exp_wdata, exp_src}) begin
                n_err++;
                $display("FAIL contention_write[%0d]: got %h want %h", k,
                         {rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o}, {exp_we, exp_waddr, exp_wdata, exp_src});
            end
        end
        n_vec++;
        if (conflict_cnt_o !== 16'd5) begin
            n_err++;
            $display("FAIL contention_cnt: got %0d want 5", conflict_cnt_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall();
        v[WB_SRC_LSU] = 1'b1; a[WB_SRC_LSU] = 5'd8;  d[WB_SRC_LSU] = $urandom;
        v[WB_SRC_MDU] = 1'b1; a[WB_SRC_MDU] = 5'd12; d[WB_SRC_MDU] = $urandom;
        tick();
        a[WB_SRC_LSU] = 5'd9; d[WB_SRC_LSU] = $urandom;
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (src_ready_o !== 3'b000) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %b want 000", k, src_ready_o);
            end
            tick();
            n_vec++;
            if (rf_we_o !== 1'b0) begin
                n_err++;
                $display("FAIL stall_we[%0d]: got %b want 0", k, rf_we_o);
            end
        end
        stall_i = 1'b0;
        #1;
        n_vec++;
        if (src_ready_o !== 3'b010) begin
            n_err++;
            $display("FAIL stall_release_ready: got %b want 010", src_ready_o);
        end
        // Keep src1 busy so the frozen src2 age decides when it finally wins.
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (src_ready_o !== exp_ready()) begin
                n_err++;
                $display("FAIL stall_after_ready[%0d]: got %b want %b", k, src_ready_o, exp_ready());
            end
            tick();
            if (last_win == WB_SRC_LSU) begin a[WB_SRC_LSU] = 5'(k + 20); d[WB_SRC_LSU] = $urandom; end
            if (last_win == WB_SRC_MDU) v[WB_SRC_MDU] = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        v[WB_SRC_ALU] = 1'b1; a[WB_SRC_ALU] = 5'd3;  d[WB_SRC_ALU] = $urandom;
        v[WB_SRC_LSU] = 1'b1; a[WB_SRC_LSU] = 5'd9;  d[WB_SRC_LSU] = $urandom;
        for (int k = 0; k < 3; k++) begin
            tick();
            d[WB_SRC_ALU] = $urandom;
        end
        flush_i = 1'b1;
        #1;
        n_vec++;
        if (src_ready_o !== 3'b000) begin
            n_err++;
            $display("FAIL flush_ready: got %b want 000", src_ready_o);
        end
        n_vec++;
        if (rf_we_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_prior_write: got %b want 1", rf_we_o);
        end
        tick();
        flush_i = 1'b0;
        n_vec++;
        if (rf_we_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_write: got %b want 0", rf_we_o);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (src_ready_o !== ((k < 4) ? 3'b001 : 3'b010)) begin
                n_err++;
                $display("FAIL flush_age_ready[%0d]: got %b want %b", k, src_ready_o,
                         (k < 4) ? 3'b001 : 3'b010);
            end
            tick();
            d[WB_SRC_ALU] = $urandom;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic prev_flush;
        for (int n = 0; n < 400; n++) begin
            prev_flush = flush_i;
            for (int i = 0; i < NS; i++) begin
                if (v[i] && last_win != i && !(prev_flush && $urandom_range(0, 1) == 1)) begin
                    v[i] = 1'b1;
                end else begin
                    v[i] = ($urandom_range(0, 99) < 55);
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    d[i] = $urandom;
                end
            end
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            #1;
            n_vec++;
            if (src_ready_o !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, src_ready_o, exp_ready());
            end
            tick();
            n_vec++;
            if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o} !== {exp_we, exp_waddr, exp_wdata, exp_src}) begin
                n_err++;
                $display("FAIL rand_write[%0d]: got %h want %h", n,
                         {rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o}, {exp_we, exp_waddr, exp_wdata, exp_src});
            end
            n_vec++;
            if (conflict_cnt_o !== 16'(exp_cnt)) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, conflict_cnt_o, exp_cnt);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        v[WB_SRC_LSU] = 1'b1; a[WB_SRC_LSU] = 5'd7;  d[WB_SRC_LSU] = 32'h1234_5678;
        v[WB_SRC_MDU] = 1'b1; a[WB_SRC_MDU] = 5'd11; d[WB_SRC_MDU] = $urandom;
        tick();
        v[WB_SRC_LSU] = 1'b0;
        n_vec++;
        if (rf_we_o !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre_we: got %b want 1", rf_we_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o} !== '0) begin
            n_err++;
            $display("FAIL areset_rf: got %h want 0", {rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o});
        end
        n_vec++;
        if (conflict_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL areset_cnt: got %0d want 0", conflict_cnt_o);
        end
        clear_inputs();
        model_reset();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_x0();
        test_contention();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
